// File: rtl/jtcps1_pkg.sv
// Shared types for the CPS1 VRAM server.
// Grant states, cache entry and defaults.
package jtcps1_pkg;

  localparam int AW = 17;
  localparam int DW = 16;

  localparam int HOLD_MAX_DEF = 64;
  localparam int BACKOFF_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAITCPU = 2'd1,
    ST_GRANT   = 2'd2,
    ST_BACKOFF = 2'd3
  } grant_st_t;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cache_t;

  function automatic int cnt_w(input int max);
    return (max < 2) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/jtcps1_vram_fetch.sv
// One-entry read cache in front of VRAM.
// Issues a read on a miss while the bus is granted.
module jtcps1_vram_fetch
  import jtcps1_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          busack,
  input  logic [AW-1:0] vram_addr,
  output logic [DW-1:0] vram_data,
  output logic          vram_ok,
  output logic          ram_req,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_data,
  input  logic          ram_rdy
);

  cache_t cache;
  logic   miss;

  assign miss      = !cache.valid ||
                     (vram_addr != cache.addr);
  assign vram_ok   = rst_n && busack && !miss;
  assign vram_data = cache.data;

  // A read in flight always completes, even if the grant is lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cache    <= '0;
      ram_req  <= 1'b0;
      ram_addr <= '0;
    end else if (ram_req) begin
      if (ram_rdy) begin
        ram_req <= 1'b0;
        cache   <= '{valid: 1'b1,
                     addr:  ram_addr,
                     data:  ram_data};
      end
    end else if (busack && miss) begin
      ram_req  <= 1'b1;
      ram_addr <= vram_addr;
    end
  end

endmodule

// File: rtl/jtcps1_vram_server.sv
// VRAM bus arbiter for the palette copier.
// Grants the bus when the CPU is idle, forces CPU slots.
module jtcps1_vram_server
  import jtcps1_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF,
  parameter int BACKOFF  = BACKOFF_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pxl_cen,
  input  logic          busreq,
  output logic          busack,
  input  logic          cpu_idle,
  input  logic          cpu_pri,
  input  logic [AW-1:0] vram_addr,
  output logic [DW-1:0] vram_data,
  output logic          vram_ok,
  output logic          ram_req,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_data,
  input  logic          ram_rdy
);

  localparam int HW = cnt_w(HOLD_MAX);
  localparam int BW = cnt_w(BACKOFF);

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
  localparam logic [HW-1:0] HOLD_TOP  = HW'(HOLD_MAX);
  localparam logic [BW-1:0] BOFF_LAST = BW'(BACKOFF - 1);

  grant_st_t       state;
  logic [HW-1:0]   hold_cnt;
  logic [BW-1:0]   boff_cnt;

  // Dropping busreq beats everything, including cpu_pri.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      busack   <= 1'b0;
      hold_cnt <= '0;
      boff_cnt <= '0;
    end else if (!busreq) begin
      state  <= ST_IDLE;
      busack <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (pxl_cen) state <= ST_WAITCPU;
        end
        ST_WAITCPU: begin
          if (pxl_cen && cpu_idle && !cpu_pri) begin
            state    <= ST_GRANT;
            busack   <= 1'b1;
            hold_cnt <= '0;
          end
        end
        ST_GRANT: begin
          if (cpu_pri) begin
            state  <= ST_WAITCPU;
            busack <= 1'b0;
          end else if (pxl_cen) begin
            if (hold_cnt == HOLD_LAST) begin
              state    <= ST_BACKOFF;
              busack   <= 1'b0;
              boff_cnt <= '0;
            end
            if (hold_cnt != HOLD_TOP)
              hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_BACKOFF: begin
          if (pxl_cen) begin
            if (boff_cnt == BOFF_LAST)
              state <= ST_WAITCPU;
            else
              boff_cnt <= boff_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  jtcps1_vram_fetch u_fetch (
    .clk       (clk),
    .rst_n     (rst_n),
    .busack    (busack),
    .vram_addr (vram_addr),
    .vram_data (vram_data),
    .vram_ok   (vram_ok),
    .ram_req   (ram_req),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram_rdy   (ram_rdy)
  );

endmodule

// File: doc/jtcps1_vram_server.md
JTCPS1_VRAM_SERVER -- requirements
Module: jtcps1_vram_server

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 64, meaning the maximum pxl_cen ticks busack stays high before a forced CPU slot.
REQ-002 SHALL have parameter BACKOFF, default 4, meaning the pxl_cen ticks busack stays low during a forced CPU slot.
REQ-003 SHALL have port clk  in  1  system clock; single clock domain, all logic on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port pxl_cen  in  1  pixel clock enable.
REQ-006 SHALL have port busreq  in  1  DMA bus request from the palette copier, level.
REQ-007 SHALL have port busack  out  1  bus grant to the palette copier, registered.
REQ-008 SHALL have port cpu_idle  in  1  high when the CPU is between bus cycles.
REQ-009 SHALL have port cpu_pri  in  1  CPU priority demand; revokes the grant.
REQ-010 SHALL have port vram_addr  in  17  word address [17:1] requested by the copier.
REQ-011 SHALL have port vram_data  out  16  read data for vram_addr.
REQ-012 SHALL have port vram_ok  out  1  vram_data is valid for the current vram_addr.
REQ-013 SHALL have port ram_req  out  1  memory read request, level, registered.
REQ-014 SHALL have port ram_addr  out  17  memory word address, registered.
REQ-015 SHALL have port ram_data  in  16  memory read data.
REQ-016 SHALL have port ram_rdy  in  1  one-clk pulse; ram_data is valid in that cycle.

Function
REQ-017 The grant FSM SHALL have states IDLE, WAITCPU, GRANT and BACKOFF; all transitions except forced revocation are qualified by pxl_cen.
REQ-018 IDLE->WAITCPU SHALL occur on pxl_cen with busreq=1.
REQ-019 WAITCPU->GRANT SHALL occur on pxl_cen with cpu_idle=1 and cpu_pri=0, setting busack=1 and clearing the hold counter.
REQ-020 In GRANT, the hold counter SHALL increment per pxl_cen; reaching HOLD_MAX with busreq still high SHALL go to BACKOFF with busack=0.
REQ-021 BACKOFF SHALL last BACKOFF pxl_cen ticks, then go to WAITCPU.
REQ-022 busreq=0 in any state SHALL go to IDLE with busack=0 on the next clk, regardless of pxl_cen.
REQ-023 cpu_pri=1 in GRANT SHALL clear busack on the next clk regardless of pxl_cen and go to WAITCPU; the hold counter restarts at the next grant.
REQ-024 If busreq=0 and cpu_pri=1 occur together, busreq=0 SHALL win (IDLE).
REQ-025 The fetch engine SHALL hold a one-entry cache: cached_addr (17b), cached_data (16b) and valid.
REQ-026 vram_ok SHALL equal busack AND valid AND (vram_addr==cached_addr); the comparison is combinational, and vram_ok has zero-cycle response to an address change.
REQ-027 vram_data SHALL be cached_data, registered.
REQ-028 When busack=1, no transaction is outstanding, and vram_addr differs from cached_addr or valid=0, ram_req SHALL go to 1 and ram_addr SHALL load vram_addr on the next clk.
REQ-029 On ram_rdy, ram_req SHALL go to 0, cached_data SHALL load ram_data, cached_addr SHALL load ram_addr, and valid SHALL go to 1, all in the same clk.
REQ-030 An outstanding transaction SHALL never be aborted; if busack drops mid-request, the fill completes and is kept.
REQ-031 A new request SHALL NOT be issued while busack=0.
REQ-032 If vram_addr changes while a request is outstanding, the returned data SHALL still fill the cache, and the new address is requested on the following clk.
REQ-033 Minimum busreq->busack latency SHALL be 2 pxl_cen ticks.
REQ-034 Minimum miss->vram_ok latency SHALL be 1 clk plus memory latency plus 0 clk.
REQ-035 The hold counter SHALL be wide enough for HOLD_MAX and SHALL saturate without wrapping.

Reset
REQ-036 While rst_n=0 at a clk edge, the FSM SHALL go to IDLE and busack, ram_req, valid, vram_data and the counters SHALL be 0, with ram_addr=0 and cached_addr=0.
REQ-037 Reset mid-transaction SHALL drop ram_req, and a ram_rdy arriving after reset SHALL be ignored.
REQ-038 vram_ok SHALL be 0 throughout reset.

Structure
REQ-039 Grant state encodings and the HOLD_MAX/BACKOFF defaults SHALL live in the shared jtcps1 package.
REQ-040 The one-entry cache and the memory request logic SHALL be the sub-module jtcps1_vram_fetch; grant arbitration SHALL stay in the top.

Verification
REQ-041 The bench SHALL cover: pxl_cen every 2nd clk, busreq 0->1, cpu_idle=1 -> busack=1 exactly 2 pxl_cen later.
REQ-042 The bench SHALL cover: busack=1, vram_addr=0x00100, memory latency 3 clk, ram_data=0xABCD -> ram_addr=0x00100, then vram_ok=1 with vram_data=0xABCD; vram_addr->0x00101 makes vram_ok=0 in the same cycle.
REQ-043 The bench SHALL cover: busreq held with HOLD_MAX=8, BACKOFF=4 -> busack high 8 ticks, low 4 ticks, high again once cpu_idle=1.
REQ-044 The bench SHALL cover: cpu_pri pulse during an outstanding read -> busack=0 next clk, fill completes, and no new ram_req until regrant.
REQ-045 The bench SHALL cover: busreq=0 and cpu_pri=1 in the same clk -> FSM in IDLE and busack=0.
REQ-046 The bench SHALL cover: rst_n=0 with ram_req=1, then ram_rdy pulse after release -> valid stays 0 and vram_ok=0.
